// File: rtl/lsu_mem_master_if.sv
// Bundles the pipeline-side request/response signals and the data-memory port of the LSU.
// The master modport is the LSU view; the slave modport is the pipeline/memory side.
interface lsu_mem_master_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          mem_cs_n;
  logic          mem_rd;
  logic [AW-3:0] mem_addr;
  logic [3:0]    mem_mask;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_cs_n, mem_rd, mem_addr, mem_mask, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_cs_n, mem_rd, mem_addr, mem_mask, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one byte-addressed request at a time onto a word memory,
// splitting word-crossing accesses in two and merging/extending load data.
module lsu_mem_master #(
  parameter int AW       = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  lsu_mem_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

  state_t        r_state, w_state_next;
  logic          r_we, r_err, r_cross;
  logic [2:0]    r_funct3;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata, r_buf0, r_buf1;

  logic          w_req_cross, w_req_illegal, w_req_err;
  logic [1:0]    w_off;
  logic [3:0]    w_base;
  logic [7:0]    w_lanes;
  logic [63:0]   w_wide;
  logic [31:0]   w_word, w_ext;
  logic [AW-3:0] w_addr_a, w_addr_b;

  // A request crosses into the next word when off+size exceeds 4 bytes.
  function automatic logic crosses(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return (off == 2'd3);
      default: return (off != 2'd0);
    endcase
  endfunction

  assign w_req_cross   = crosses(bus.req_funct3[1:0], bus.req_addr[1:0]);
  assign w_req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                         (bus.req_funct3[2] && bus.req_we);
  assign w_req_err     = w_req_illegal || ((SPLIT_EN == 1'b0) && w_req_cross);

  assign w_off    = r_addr[1:0];
  assign w_addr_a = r_addr[AW-1:2];
  assign w_addr_b = w_addr_a + {{(AW-3){1'b0}}, 1'b1};

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_base = 4'b0001;
      2'b01:   w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
  end

  // Lanes and store data laid over the 8-byte window {word A+1, word A}.
  assign w_lanes = {4'b0000, w_base} << w_off;
  assign w_wide  = {32'h0, r_wdata} << {w_off, 3'b000};
  assign w_word  = 32'({r_buf1, r_buf0} >> {w_off, 3'b000});

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{24{w_word[7]}}, w_word[7:0]};
      3'b001:  w_ext = {{16{w_word[15]}}, w_word[15:0]};
      3'b100:  w_ext = {24'h0, w_word[7:0]};
      3'b101:  w_ext = {16'h0, w_word[15:0]};
      default: w_ext = w_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_cross  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_buf0   <= 32'h0;
      r_buf1   <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && bus.req_valid) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_err    <= w_req_err;
        r_cross  <= w_req_cross;
      end
      if (r_state == S_ACC0 && !r_err && !r_we && bus.mem_ack)
        r_buf0 <= bus.mem_rdata;
      if (r_state == S_ACC1 && !r_we && bus.mem_ack)
        r_buf1 <= bus.mem_rdata;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bus.req_ready = 1'b0;
    bus.mem_cs_n  = 1'b1;
    bus.mem_rd    = 1'b1;
    bus.mem_addr  = '0;
    bus.mem_mask  = 4'b0000;
    bus.mem_wdata = 32'h0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'h0;
    bus.rsp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_state_next = S_ACC0;
      end
      S_ACC0: begin
        // Rejected requests spend this cycle deselected so the response timing matches a hit.
        if (r_err) begin
          w_state_next = S_RESP;
        end else begin
          bus.mem_cs_n  = 1'b0;
          bus.mem_rd    = !r_we;
          bus.mem_addr  = w_addr_a;
          bus.mem_mask  = r_we ? w_lanes[3:0] : 4'b1111;
          bus.mem_wdata = r_we ? w_wide[31:0] : 32'h0;
          if (bus.mem_ack) w_state_next = r_cross ? S_ACC1 : S_RESP;
        end
      end
      S_ACC1: begin
        bus.mem_cs_n  = 1'b0;
        bus.mem_rd    = !r_we;
        bus.mem_addr  = w_addr_b;
        bus.mem_mask  = r_we ? w_lanes[7:4] : 4'b1111;
        bus.mem_wdata = r_we ? w_wide[63:32] : 32'h0;
        if (bus.mem_ack) w_state_next = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = r_err;
        bus.rsp_rdata = (r_we || r_err) ? 32'h0 : w_ext;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: vector table over a word-memory model plus
// hand sequences for wait states, busy-time requests, reset mid-access and SPLIT_EN=0.
module tb_lsu_mem_master;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if #(.AW(32)) bus ();
  lsu_mem_master_if #(.AW(32)) bus0 ();

  lsu_mem_master #(.AW(32), .SPLIT_EN(1'b1)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  lsu_mem_master #(.AW(32), .SPLIT_EN(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: 256 words, ack after ack_delay select cycles, byte-masked writes.
  typedef struct {
    logic        rd;
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } acc_t;

  logic [31:0] mem [256];
  acc_t        log_q[$];
  int unsigned ack_delay = 0;
  int unsigned wait_cnt;

  assign bus.mem_ack   = !bus.mem_cs_n && (wait_cnt >= ack_delay);
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (!bus.mem_cs_n) wait_cnt <= bus.mem_ack ? 0 : wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) begin
    if (reset && !bus.mem_cs_n && bus.mem_ack) begin
      log_q.push_back('{bus.mem_rd, bus.mem_addr, bus.mem_mask, bus.mem_wdata});
      if (!bus.mem_rd)
        for (int b = 0; b < 4; b++)
          if (bus.mem_mask[b]) mem[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  assign bus0.mem_ack   = !bus0.mem_cs_n;
  assign bus0.mem_rdata = 32'h0;

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic err);
    lat = -1;
    rd  = 32'hx;
    err = 1'bx;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = c;
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        break;
      end
    end
    if (lat < 0) begin
      check("rsp_timeout", 32'h0, 32'h1);
    end else begin
      @(negedge clk);
      check("rsp_pulse_one_cycle", 32'(bus.rsp_valid), 32'h0);
      check("req_ready_after_rsp", 32'(bus.req_ready), 32'h1);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_acc;
    logic [31:0] exp_m0;
    logic [31:0] exp_m1;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  initial begin
    int          lat;
    int          lat2;
    logic [31:0] rd;
    logic        err;
    logic [7:0]  i0, i1;
    vec_t        v;
    bit          seen;

    //            we   f3      addr          wdata         m0            m1            rdata         err lat acc exp_m0        exp_m1
    vec[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 32'hDEADBEEF, 32'h0};
    vec[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF0000, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 32'h80FF0000, 32'h0};
    vec[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF0000, 32'h0,        32'h00000080, 1'b0, 2, 1, 32'h80FF0000, 32'h0};
    vec[3]  = '{1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'hAB000000, 32'h000000CD, 32'hFFFFCDAB, 1'b0, 3, 2, 32'hAB000000, 32'h000000CD};
    vec[4]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80010000, 32'h0,        32'h00008001, 1'b0, 2, 1, 32'h80010000, 32'h0};
    vec[5]  = '{1'b0, 3'b010, 32'h0000_0105, 32'h0,        32'h44332211, 32'h88776655, 32'h55443322, 1'b0, 3, 2, 32'h44332211, 32'h88776655};
    vec[6]  = '{1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0,        32'h44332211, 32'h88776655, 32'h55443322, 1'b0, 3, 2, 32'h44332211, 32'h88776655};
    vec[7]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h12345678, 32'h0,        32'h0,        1'b1, 2, 0, 32'h12345678, 32'h0};
    vec[8]  = '{1'b1, 3'b100, 32'h0000_0100, 32'hFFFFFFFF, 32'h12345678, 32'h0,        32'h0,        1'b1, 2, 0, 32'h12345678, 32'h0};
    vec[9]  = '{1'b1, 3'b000, 32'h0000_0102, 32'h000000A5, 32'h11223344, 32'h0,        32'h0,        1'b0, 2, 1, 32'h11A53344, 32'h0};
    vec[10] = '{1'b1, 3'b010, 32'h0000_0101, 32'h11223344, 32'h0,        32'h0,        32'h0,        1'b0, 3, 2, 32'h22334400, 32'h00000011};
    vec[11] = '{1'b1, 3'b001, 32'h0000_0107, 32'h0000BEEF, 32'h0,        32'h0,        32'h0,        1'b0, 3, 2, 32'hEF000000, 32'h000000BE};
    vec[12] = '{1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000007F, 32'h0,        32'h0000007F, 1'b0, 2, 1, 32'h0000007F, 32'h0};
    vec[13] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h00FEDC00, 32'h0,        32'hFFFFFEDC, 1'b0, 2, 1, 32'h00FEDC00, 32'h0};

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus0.req_valid  = 1'b0;
    bus0.req_we     = 1'b0;
    bus0.req_funct3 = 3'b000;
    bus0.req_addr   = 32'h0;
    bus0.req_wdata  = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'h1);
    check("rst_cs_n",      32'(bus.mem_cs_n),  32'h1);
    check("rst_rd",        32'(bus.mem_rd),    32'h1);
    check("rst_addr",      32'(bus.mem_addr),  32'h0);
    check("rst_mask",      32'(bus.mem_mask),  32'h0);
    check("rst_wdata",     bus.mem_wdata,      32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      v  = vec[i];
      i0 = v.addr[9:2];
      i1 = i0 + 8'd1;
      mem[i0] <= v.m0;
      mem[i1] <= v.m1;
      log_q.delete();
      run_req(v.we, v.f3, v.addr, v.wdata, lat, rd, err);
      check($sformatf("v%0d_rdata", i), rd, v.exp_rdata);
      check($sformatf("v%0d_err", i), 32'(err), 32'(v.exp_err));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
      check($sformatf("v%0d_accesses", i), 32'(log_q.size()), 32'(v.exp_acc));
      check($sformatf("v%0d_mem0", i), mem[i0], v.exp_m0);
      check($sformatf("v%0d_mem1", i), mem[i1], v.exp_m1);
      $display("vec %0d: we=%0b f3=%03b addr=%h rdata=%h err=%0b lat=%0d", i, v.we, v.f3, v.addr, rd, err, lat);
    end

    // Misaligned word store: lane and data layout of both halves.
    mem[8'h40] <= 32'h0;
    mem[8'h41] <= 32'h0;
    log_q.delete();
    run_req(1'b1, 3'b010, 32'h0000_0101, 32'h11223344, lat, rd, err);
    check("sw_split_count", 32'(log_q.size()), 32'h2);
    if (log_q.size() == 2) begin
      check("sw_acc0_rd",    32'(log_q[0].rd),    32'h0);
      check("sw_acc0_addr",  32'(log_q[0].addr),  32'h40);
      check("sw_acc0_mask",  32'(log_q[0].mask),  32'hE);
      check("sw_acc0_wdata", log_q[0].wdata,      32'h22334400);
      check("sw_acc1_addr",  32'(log_q[1].addr),  32'h41);
      check("sw_acc1_mask",  32'(log_q[1].mask),  32'h1);
      check("sw_acc1_wdata", log_q[1].wdata,      32'h00000011);
    end
    $display("seq sw_split: accesses=%0d", log_q.size());

    // Word address wrap on the second half of a crossing load.
    log_q.delete();
    run_req(1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0, lat, rd, err);
    check("wrap_count", 32'(log_q.size()), 32'h2);
    if (log_q.size() == 2) begin
      check("wrap_acc0_addr", 32'(log_q[0].addr), 32'h3FFFFFFF);
      check("wrap_acc1_addr", 32'(log_q[1].addr), 32'h0);
      check("wrap_read_mask", 32'(log_q[1].mask), 32'hF);
    end
    $display("seq wrap: rdata=%h", rd);

    // Two wait states, with a second request held valid the whole time it is busy.
    ack_delay = 2;
    mem[8'h40] <= 32'hCAFEF00D;
    log_q.delete();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0100;
    @(posedge clk);
    #1 bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0000_0200;
    lat2 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("busy_req_ready", 32'(bus.req_ready), 32'h0);
        check("busy_cs_n",      32'(bus.mem_cs_n),  32'h0);
        check("busy_addr_held", 32'(bus.mem_addr),  32'h40);
      end
      if (bus.rsp_valid) begin
        lat2 = c;
        rd   = bus.rsp_rdata;
        bus.req_valid = 1'b0;
        break;
      end
    end
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_latency", 32'(lat2), 32'h4);
    check("wait_rdata",   rd,        32'hCAFEF00D);
    check("busy_ignored", 32'(log_q.size()), 32'h1);
    $display("seq wait2: lat=%0d rdata=%h accesses=%0d", lat2, rd, log_q.size());

    // Reset while the memory is stalling.
    ack_delay = 100;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0100;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_cs_n", 32'(bus.mem_cs_n), 32'h0);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_cs_n",      32'(bus.mem_cs_n),  32'h1);
    check("rst_mid_req_ready", 32'(bus.req_ready), 32'h1);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("rst_mid_no_rsp", 32'(seen), 32'h0);
    $display("seq reset_mid_access: rsp_seen=%0b", seen);

    // SPLIT_EN=0: misaligned word load is rejected without touching memory.
    @(negedge clk);
    bus0.req_valid  = 1'b1;
    bus0.req_we     = 1'b0;
    bus0.req_funct3 = 3'b010;
    bus0.req_addr   = 32'h0000_0102;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    lat2 = -1;
    err  = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (!bus0.mem_cs_n) seen = 1'b1;
      if (bus0.rsp_valid) begin
        lat2 = c;
        err  = bus0.rsp_err;
        break;
      end
    end
    check("nosplit_err",     32'(err),  32'h1);
    check("nosplit_latency", 32'(lat2), 32'h2);
    check("nosplit_no_sel",  32'(seen), 32'h0);
    $display("seq nosplit: err=%0b lat=%0d selected=%0b", err, lat2, seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
